// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_mem_arbiter_if
// Bundles the bus signals around the data-memory arbiter.
//   IFU side : ifu_req_valid/ifu_req_ready/ifu_addr,
//              ifu_resp_valid/ifu_rdata
//   LSU side : lsu_req_valid/lsu_req_ready/lsu_wen/lsu_addr/lsu_wdata/
//              lsu_wmask, lsu_resp_valid/lsu_rdata
//   MEM side : mem_req_valid/mem_req_ready/mem_wen/mem_addr/mem_wdata/
//              mem_wmask, mem_resp_valid/mem_rdata
// Modports:
//   slave  - arbiter view. It serves the IFU/LSU requests and drives the
//            memory request channel.
//   master - environment view. The requesters and the memory drive their
//            inputs and observe the arbiter.
// ----------------------------------------------------------------------------
interface ysyx_23060332_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/ysyx_23060332_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_mem_arbiter
// Shares one handshaked, variable-latency data-memory port between the IFU
// (read-only fetches) and the LSU (loads/stores). Only one transaction is in
// flight at a time. The LSU has priority. A burst counter hands the port to
// a waiting IFU after LSU_BURST_MAX back-to-back LSU grants.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave modport of ysyx_23060332_mem_arbiter_if (IFU, LSU and
//           memory channels)
//
// Flow: IDLE (arbitrate and latch the payload) -> REQ (hold the memory
// request until it is accepted) -> RESP (wait for the response and pass it
// to the owner) -> IDLE.
// ----------------------------------------------------------------------------
module ysyx_23060332_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int LSU_BURST_MAX = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  ysyx_23060332_mem_arbiter_if.slave        bus
);

  localparam int CNT_W = $clog2(LSU_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(LSU_BURST_MAX);
  localparam logic [CNT_W-1:0] BURST_ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              wen_q,   wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [CNT_W-1:0]  burst_q, burst_d;

  logic ifu_priority_s;
  logic grant_ifu_s;
  logic grant_lsu_s;
  logic req_phase_s;
  logic resp_fire_s;
  logic ifu_resp_s;
  logic lsu_resp_s;

  // A waiting IFU overrides the LSU once the LSU has used up its burst allowance.
  assign ifu_priority_s = bus.ifu_req_valid && (burst_q == BURST_MAX_C);

  // Arbitration. Grants are only possible in IDLE.
  always_comb begin
    grant_ifu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.lsu_req_valid && !ifu_priority_s) begin
        grant_lsu_s = 1'b1;
      end else if (bus.ifu_req_valid) begin
        grant_ifu_s = 1'b1;
      end else begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
      end
    end else begin
      grant_ifu_s = 1'b0;
      grant_lsu_s = 1'b0;
    end
  end

  // Next-state, payload and burst-counter computation.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_lsu_s) begin
          state_d = ST_REQ;
          owner_d = OWN_LSU;
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
          // Count only grants that made the IFU wait; saturate at the limit.
          if (bus.ifu_req_valid) begin
            burst_d = (burst_q == BURST_MAX_C) ? burst_q : (burst_q + BURST_ONE_C);
          end else begin
            burst_d = '0;
          end
        end else if (grant_ifu_s) begin
          // Fetches are reads: never let stale store fields reach memory.
          state_d = ST_REQ;
          owner_d = OWN_IFU;
          addr_d  = bus.ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = 8'h00;
          burst_d = '0;
        end else begin
          // No requester at all, so the IFU is not waiting either.
          state_d = ST_IDLE;
          burst_d = '0;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (bus.mem_resp_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, owner, payload and burst-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= 8'h00;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      burst_q <= burst_d;
    end
  end

  assign req_phase_s = (state_q == ST_REQ);
  // Responses outside RESP are stray (for example, late after a reset) and are dropped.
  assign resp_fire_s = (state_q == ST_RESP) && bus.mem_resp_valid;
  assign ifu_resp_s  = resp_fire_s && (owner_q == OWN_IFU);
  assign lsu_resp_s  = resp_fire_s && (owner_q == OWN_LSU);

  // The state resets to IDLE, where grants are combinational. Gate the ready
  // outputs with rst_n so that no handshake can complete while in reset.
  assign bus.ifu_req_ready  = grant_ifu_s && rst_n;
  assign bus.lsu_req_ready  = grant_lsu_s && rst_n;

  // Drive the memory request only from the latched payload, which stays stable
  // for the whole REQ phase. Force it to zero elsewhere.
  assign bus.mem_req_valid  = req_phase_s;
  assign bus.mem_wen        = req_phase_s ? wen_q   : 1'b0;
  assign bus.mem_addr       = req_phase_s ? addr_q  : '0;
  assign bus.mem_wdata      = req_phase_s ? wdata_q : '0;
  assign bus.mem_wmask      = req_phase_s ? wmask_q : 8'h00;

  assign bus.ifu_resp_valid = ifu_resp_s;
  assign bus.ifu_rdata      = ifu_resp_s ? bus.mem_rdata : '0;
  assign bus.lsu_resp_valid = lsu_resp_s;
  assign bus.lsu_rdata      = lsu_resp_s ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060332_mem_arbiter
// Scoreboard bench for the IFU/LSU data-memory arbiter.
// Requester tasks push expected memory requests and responses on handshake.
// A monitor pops and compares them when the DUT presents them.
// A simple memory agent supplies stall and latency behaviour.
// ----------------------------------------------------------------------------
module tb_ysyx_23060332_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } mem_txn_t;

  logic clk;
  logic rst_n;

  ysyx_23060332_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ysyx_23060332_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LSU_BURST_MAX(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] ifu_exp[$];
  logic [31:0] lsu_exp[$];
  mem_txn_t    mem_exp[$];
  byte         grant_log[$];

  int ifu_grant_cyc, lsu_grant_cyc;
  int last_mem_acc_cyc, last_ifu_resp_cyc, last_lsu_resp_cyc;
  int n_lsu_resp = 0;

  // Memory-agent configuration and state.
  int          cfg_stall = 0;
  int          cfg_resp_delay = 0;
  int          inject_req = 0;
  int          inject_ack = 0;
  bit          m_pending, m_seen;
  int          m_stall_left, m_wait;
  logic [31:0] m_data;
  mem_txn_t    mon_t;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_for(input logic [31:0] a, input logic w);
    if (w) return 32'h0000_0000;
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory agent: drives its outputs 1 time unit after each rising edge.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    m_pending = 1'b0; m_seen = 1'b0; m_stall_left = 0; m_wait = 0; m_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = 32'h0;
      if (!rst_n) begin
        m_pending = 1'b0;
        m_seen    = 1'b0;
      end else begin
        if (inject_req != inject_ack) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = 32'hBAD0_BAD0;
          inject_ack         = inject_req;
        end else if (m_pending) begin
          if (m_wait > 0) m_wait--;
          else begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = m_data;
            m_pending          = 1'b0;
          end
        end
        if (bus.mem_req_valid && !m_pending) begin
          if (!m_seen) begin
            m_seen       = 1'b1;
            m_stall_left = cfg_stall;
          end
          if (m_stall_left > 0) m_stall_left--;
          else begin
            bus.mem_req_ready = 1'b1;
            m_pending = 1'b1;
            m_seen    = 1'b0;
            m_wait    = cfg_resp_delay;
            m_data    = data_for(bus.mem_addr, bus.mem_wen);
          end
        end
      end
    end
  end

  // Monitor: compares memory requests and responses against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          last_mem_acc_cyc = cyc;
          if (mem_exp.size() == 0) check_eq("mem_req_unexpected", 1'b1, 1'b0);
          else begin
            mon_t = mem_exp.pop_front();
            check_eq("mem_addr",  bus.mem_addr,  mon_t.addr);
            check_eq("mem_wen",   bus.mem_wen,   mon_t.wen);
            check_eq("mem_wdata", bus.mem_wdata, mon_t.wdata);
            check_eq("mem_wmask", bus.mem_wmask, mon_t.wmask);
          end
        end
        check_eq("resp_both", bus.ifu_resp_valid && bus.lsu_resp_valid, 1'b0);
        if (bus.ifu_resp_valid) begin
          last_ifu_resp_cyc = cyc;
          if (ifu_exp.size() == 0) check_eq("ifu_resp_unexpected", 1'b1, 1'b0);
          else check_eq("ifu_rdata", bus.ifu_rdata, ifu_exp.pop_front());
        end else begin
          check_eq("ifu_rdata_zero", bus.ifu_rdata, 32'h0);
        end
        if (bus.lsu_resp_valid) begin
          last_lsu_resp_cyc = cyc;
          n_lsu_resp++;
          if (lsu_exp.size() == 0) check_eq("lsu_resp_unexpected", 1'b1, 1'b0);
          else check_eq("lsu_rdata", bus.lsu_rdata, lsu_exp.pop_front());
        end else begin
          check_eq("lsu_rdata_zero", bus.lsu_rdata, 32'h0);
        end
      end
    end
  end

  // Callers must invoke the requester tasks 2 time units after a rising edge.
  task automatic ifu_issue(input logic [31:0] a);
    bit got = 1'b0;
    mem_txn_t t;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = a;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.ifu_req_ready) begin
        got = 1'b1;
        ifu_grant_cyc = cyc;
        grant_log.push_back("I");
        ifu_exp.push_back(data_for(a, 1'b0));
        t.addr = a; t.wen = 1'b0; t.wdata = 32'h0; t.wmask = 8'h00;
        mem_exp.push_back(t);
      end
    end
    @(posedge clk); #2;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0;
    if (!got) check_eq("ifu_grant_timeout", 1'b0, 1'b1);
  endtask

  task automatic lsu_issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    bit got = 1'b0;
    mem_txn_t t;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen = w; bus.lsu_addr = a; bus.lsu_wdata = d; bus.lsu_wmask = m;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.lsu_req_ready) begin
        got = 1'b1;
        lsu_grant_cyc = cyc;
        grant_log.push_back("L");
        lsu_exp.push_back(data_for(a, w));
        t.addr = a; t.wen = w; t.wdata = d; t.wmask = m;
        mem_exp.push_back(t);
      end
    end
    @(posedge clk); #2;
    bus.lsu_req_valid = 1'b0;
    if (!got) check_eq("lsu_grant_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ifu_exp.size() == 0 && lsu_exp.size() == 0 && mem_exp.size() == 0) ok = 1'b1;
    end
    check_eq("drain_timeout", ok, 1'b1);
    @(posedge clk); #2;
  endtask

  task automatic check_order(input string pfx, input string exp_s);
    check_eq({pfx, "_len"}, grant_log.size(), exp_s.len());
    for (int i = 0; i < exp_s.len(); i++) begin
      byte g;
      g = (i < grant_log.size()) ? grant_log[i] : 8'h00;
      check_eq($sformatf("%s_%0d", pfx, i), g, exp_s[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0000;
    bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_addr = 32'h8000_1000;
    bus.lsu_wdata = 32'hFFFF_FFFF; bus.lsu_wmask = 8'hFF;
    // Outputs must stay 0 during reset, even while requests are pending.
    @(negedge clk);
    check_eq("rst_ifu_ready", bus.ifu_req_ready, 1'b0);
    check_eq("rst_lsu_ready", bus.lsu_req_ready, 1'b0);
    check_eq("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check_eq("rst_mem_addr",  bus.mem_addr, 32'h0);
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_mem_valid", bus.mem_req_valid, 1'b0);
    check_eq("post_rst_ifu_resp",  bus.ifu_resp_valid, 1'b0);
    check_eq("post_rst_lsu_resp",  bus.lsu_resp_valid, 1'b0);
    @(posedge clk); #2;

    // Single fetch with minimum latency; LSU store fields held as junk.
    ifu_issue(32'h8000_0000);
    wait_done();
    check_eq("fetch_mem_lat",  last_mem_acc_cyc  - ifu_grant_cyc, 1);
    check_eq("fetch_resp_lat", last_ifu_resp_cyc - ifu_grant_cyc, 2);

    // Collision: LSU first, IFU in the next IDLE.
    grant_log.delete();
    fork
      ifu_issue(32'h8000_0004);
      lsu_issue(1'b0, 32'h8000_1000, 32'h1234_5678, 8'h00);
    join
    wait_done();
    check_order("coll", "LI");
    check_eq("coll_lsu_first", last_lsu_resp_cyc < ifu_grant_cyc, 1'b1);

    // Starvation guard: four LSU grants, then one IFU grant, then repeat.
    grant_log.delete();
    fork
      for (int i = 0; i < 2; i++) ifu_issue(32'h8000_0100 + 32'(4 * i));
      for (int j = 0; j < 9; j++) lsu_issue(1'b0, 32'h8000_3000 + 32'(4 * j), 32'(j), 8'(j));
    join
    wait_done();
    check_order("starve", "LLLLILLLLIL");

    // Backpressure: store held stable through 3 stall cycles and the accept cycle.
    begin
      int acks;
      acks = n_lsu_resp;
      cfg_stall = 3;
      lsu_issue(1'b1, 32'h8000_2000, 32'hDEAD_BEEF, 8'h0F);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_eq($sformatf("bp_valid_%0d", k), bus.mem_req_valid, 1'b1);
        check_eq($sformatf("bp_addr_%0d",  k), bus.mem_addr,  32'h8000_2000);
        check_eq($sformatf("bp_wdata_%0d", k), bus.mem_wdata, 32'hDEAD_BEEF);
        check_eq($sformatf("bp_wmask_%0d", k), bus.mem_wmask, 8'h0F);
        check_eq($sformatf("bp_wen_%0d",   k), bus.mem_wen,   1'b1);
      end
      cfg_stall = 0;
      @(posedge clk); #2;
      wait_done();
      check_eq("bp_store_ack", n_lsu_resp - acks, 1);
    end

    // Spurious response while IDLE.
    inject_req++;
    @(negedge clk);
    @(negedge clk);
    check_eq("spur_ifu_resp",  bus.ifu_resp_valid, 1'b0);
    check_eq("spur_lsu_resp",  bus.lsu_resp_valid, 1'b0);
    check_eq("spur_mem_valid", bus.mem_req_valid,  1'b0);
    @(posedge clk); #2;
    ifu_issue(32'h8000_0008);
    wait_done();
    check_eq("spur_fetch_lat", last_ifu_resp_cyc - ifu_grant_cyc, 2);

    // Reset while waiting in RESP, then a late response, then a normal fetch.
    cfg_resp_delay = 5;
    lsu_issue(1'b0, 32'h8000_4000, 32'h0, 8'h00);
    @(posedge clk); #2;
    bus.lsu_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rr_mem_valid", bus.mem_req_valid,  1'b0);
    check_eq("rr_lsu_resp",  bus.lsu_resp_valid, 1'b0);
    check_eq("rr_lsu_ready", bus.lsu_req_ready,  1'b0);
    check_eq("rr_ifu_ready", bus.ifu_req_ready,  1'b0);
    check_eq("rr_mem_addr",  bus.mem_addr,       32'h0);
    bus.lsu_req_valid = 1'b0;
    lsu_exp.delete();
    mem_exp.delete();
    cfg_resp_delay = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    inject_req++;
    @(negedge clk);
    @(negedge clk);
    check_eq("late_ifu_resp", bus.ifu_resp_valid, 1'b0);
    check_eq("late_lsu_resp", bus.lsu_resp_valid, 1'b0);
    @(posedge clk); #2;
    ifu_issue(32'h8000_0010);
    wait_done();
    check_eq("rr_fetch_lat", last_ifu_resp_cyc - ifu_grant_cyc, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060332_mem_arbiter.md
Name: ysyx_23060332_mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the single data-memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores issued by the execute stage). It replaces the current direct combinational memory hookup with a handshaked, variable-latency memory interface. Only one transaction is outstanding at a time. The LSU has priority, with an anti-starvation counter that guarantees IFU progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LSU_BURST_MAX, 4, maximum consecutive LSU grants while the IFU is waiting (must be ≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  fetch data valid, one-cycle pulse
ifu_rdata  out  DATA_W  fetch data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  access address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  8  store byte mask
lsu_resp_valid  out  1  load data or store acknowledge, one-cycle pulse
lsu_rdata  out  DATA_W  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_wen  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_wmask  out  8  byte mask
mem_resp_valid  in  1  memory response (also returned for writes)
mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, owner=IFU, burst_cnt=0, payload registers=0. All outputs are 0 while in reset and immediately after it.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Arbitrate among the valid requesters.
  - LSU wins, unless ifu_req_valid && burst_cnt==LSU_BURST_MAX, in which case IFU wins.
  - The winner's req_ready is driven combinationally high in this same cycle. The handshake completes here.
  - Latch owner, addr, wen, wdata, and wmask. An IFU grant forces wen=0, wmask=0, wdata=0.
  - Go to REQ. With no valid requester, stay in IDLE and keep both req_ready signals low.
- REQ:
  - mem_req_valid=1; mem_* driven from the latched registers, stable until accepted.
  - On mem_req_ready=1, go to RESP. Otherwise hold.
  - Both req_ready signals are 0 in REQ and RESP.
- RESP:
  - Wait for mem_resp_valid.
  - In the response cycle, the owner's resp_valid=1 and its rdata=mem_rdata (combinational pass-through). Go to IDLE.
  - The non-owner's resp_valid stays 0. rdata outputs are 0 when their resp_valid is 0.
- Minimum latency: 3 cycles from request (grant cycle) → REQ with ready → RESP with resp_valid.
- No new grant occurs in the response cycle; the next grant is the following IDLE cycle.
- Burst counter:
  - On an LSU grant while ifu_req_valid=1: burst_cnt++ (saturates at LSU_BURST_MAX).
  - On an IFU grant, or any IDLE cycle with ifu_req_valid=0: burst_cnt=0.
- mem_resp_valid in IDLE or REQ is ignored (not forwarded, no state change).
- Requesters must hold valid and payload until req_ready. The arbiter does not require valid to stay high after the handshake.
- Reset mid-transaction: abort to IDLE. Any late memory response arriving afterwards is dropped per the rule above. The memory side is reset by the same rst_n.

Test Plan:
- Single fetch: ifu_req_valid=1, ifu_addr=0x80000000, mem_req_ready=1, mem_resp_valid one cycle later with mem_rdata=0x00000413 → ifu_req_ready in cycle 0, mem_req_valid with mem_addr=0x80000000 and mem_wen=0 in cycle 1, ifu_resp_valid=1 with ifu_rdata=0x00000413 in cycle 2.
- Collision: IFU (0x80000004) and LSU load (0x80001000) valid in the same cycle → LSU granted first and lsu_resp_valid returned; IFU granted in the next IDLE, ifu_req_ready=0 until then.
- Starvation: both valid continuously, LSU_BURST_MAX=4 → grant order LSU, LSU, LSU, LSU, IFU, LSU…; burst_cnt returns to 0 after the IFU grant.
- Backpressure: LSU store with addr=0x80002000, wdata=0xDEADBEEF, wmask=0x0F, and mem_req_ready=0 for 3 cycles → mem_* stable and mem_req_valid=1 all 4 cycles; store ack produces an lsu_resp_valid pulse.
- Spurious response: mem_resp_valid=1 while IDLE → no resp_valid on either side, FSM stays IDLE.
- Reset in RESP: rst_n low for 1 cycle mid-wait → all outputs 0 immediately; a subsequent mem_resp_valid is ignored; a new IFU request is served normally.
